// File: rtl/washer_timer_sensor.sv
// washer_timer_sensor: water-level model and wash/rinse/spin phase timer feeding the washer controller.
module washer_timer_sensor #(
    parameter int CLK_DIV     = 4,
    parameter int WASH_TICKS  = 8,
    parameter int RINSE_TICKS = 6,
    parameter int SPIN_TICKS  = 5,
    parameter int LEVEL_MAX   = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_value_on,
    input  logic             drain_value_on,
    input  logic             motor_on,
    input  logic             door_lock,
    input  logic             water_wash,
    output logic             filled,
    output logic             drained,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] level,
    output logic [2:0]       phase,
    output logic             fault
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WASH_D   = CNT_W'(WASH_TICKS == 0 ? 1 : WASH_TICKS);
    localparam logic [CNT_W-1:0] RINSE_D  = CNT_W'(RINSE_TICKS == 0 ? 1 : RINSE_TICKS);
    localparam logic [CNT_W-1:0] SPIN_D   = CNT_W'(SPIN_TICKS == 0 ? 1 : SPIN_TICKS);
    localparam logic [CNT_W-1:0] LM       = CNT_W'(LEVEL_MAX);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        AGITATE   = 3'd1,
        AGI_DONE  = 3'd2,
        SPIN      = 3'd3,
        SPIN_DONE = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    pre;
    logic             tick;
    logic [CNT_W-1:0] cnt, dur;

    assign tick    = pre == PRE_LAST;
    assign filled  = level == LM;
    assign drained = level == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre <= '0;
        else        pre <= tick ? '0 : pre + 1'b1;
    end

    // Simultaneous fill and drain holds the level and latches the fault on any clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            fault <= 1'b0;
        end else begin
            if (tick && fill_value_on && !drain_value_on && level < LM) level <= level + 1'b1;
            else if (tick && drain_value_on && !fill_value_on && level != '0) level <= level - 1'b1;
            if (fill_value_on && drain_value_on) fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            dur   <= WASH_D;
        end else begin
            state <= state_n;
            if (state_n != state) cnt <= '0;
            else if (tick && (state == AGITATE || state == SPIN)) cnt <= cnt + 1'b1;
            if (state == IDLE && state_n == AGITATE) dur <= water_wash ? RINSE_D : WASH_D;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:
                if (motor_on && door_lock) state_n = AGITATE;
                else if (drain_value_on && water_wash && drained && door_lock) state_n = SPIN;
            AGITATE:
                if (!door_lock) state_n = IDLE;
                else if (tick && cnt == dur - 1'b1) state_n = AGI_DONE;
            AGI_DONE:
                if (!door_lock || !motor_on) state_n = IDLE;
            SPIN:
                if (!door_lock) state_n = IDLE;
                else if (tick && cnt == SPIN_D - 1'b1) state_n = SPIN_DONE;
            SPIN_DONE:
                if (!drain_value_on || !door_lock) state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    always_comb begin
        cycle_timeout = state == AGI_DONE;
        spin_timeout  = state == SPIN_DONE;
        phase         = state;
    end
endmodule
